sub_writeback_stage: RTL
========================

Name: sub_writeback_stage

Overview:
- Downstream consumer of the 16-bit subtractor (a16bitsub). Accepts each difference/borrow result with a valid/ready handshake.
- Derives Z/N/C/V status flags at capture time. Buffers up to two results.
- Drains them one per cycle into the register-file write port and updates the architectural flag register at retirement.

Parameters:
- N, 16, datapath width; must equal the subtractor width.
- ADDR_W, 3, register-file address width (8 registers; r0 reads as zero).
- DEPTH, 2, buffer entries; fixed at 2, any other value is unsupported.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept; high when buffer occupancy < 2; no combinational dependence on rf_ready.
- in_diff  input  N  subtractor difference.
- in_bo  input  1  subtractor borrow-out.
- in_a_msb  input  1  minuend MSB, used for overflow.
- in_b_msb  input  1  subtrahend MSB, used for overflow.
- in_rd  input  ADDR_W  destination register.
- in_flag_we  input  1  instruction updates flags.
- rf_we  output  1  register-file write strobe.
- rf_waddr  output  ADDR_W  write address.
- rf_wdata  output  N  write data.
- rf_ready  input  1  register file accepts write this cycle.
- flag_z  output  1  zero flag, registered.
- flag_n  output  1  negative flag, registered.
- flag_c  output  1  borrow flag, registered.
- flag_v  output  1  signed-overflow flag, registered.
- occupancy  output  2  entries held (0..2).

Behaviour:
- Reset (async, rst=1): occupancy=0; read/write pointers=0; all storage=0; flags=0000; rf_we=0; rf_waddr=0; rf_wdata=0; in_ready=0 while rst is high and 1 in the first cycle after release. Reset mid-drain discards buffered entries. No partial write or flag update occurs.
- Push: in_valid & in_ready at a rising edge stores one entry. The entry holds {diff, rd, flag_we, z, n, c, v}:
  - z = (in_diff == 0)
  - n = in_diff[N-1]
  - c = in_bo
  - v = (in_a_msb ^ in_b_msb) & (in_a_msb ^ in_diff[N-1])
- Upstream holds its inputs stable while in_valid & !in_ready. Inputs are ignored when in_valid=0.
- Head presentation: when occupancy>0, rf_waddr/rf_wdata reflect the head entry.
  - rf_we = (occupancy>0) & (head.rd != 0).
  - When occupancy=0, rf_we=0 and the address/data outputs hold their last values.
- Retire:
  - Head with rd!=0 retires on an edge where rf_we & rf_ready.
  - Head with rd==0 retires unconditionally on the next edge, does not wait for rf_ready, and never asserts rf_we.
- Flag update: on the retiring edge, if head.flag_we=1, flag_{z,n,c,v} load the head's stored flags. Otherwise the flags hold. New flags are visible the cycle after retirement.
- Latency: a push at edge T makes rf_we visible in cycle T+1. Best-case retirement is at edge T+1. Throughput is 1 per cycle sustained.
- Simultaneous push and retire:
  - occupancy=1: occupancy stays 1 and pointers both advance.
  - occupancy=2: no push is possible (in_ready=0); retire drops occupancy to 1, and in_ready rises the next cycle.
- Pointers are 1 bit each and wrap 1→0. Occupancy never exceeds 2 or underflows below 0.
- Order: strictly FIFO; results retire in arrival order.

Decomposition:
- Package sub_wb_pkg:
  - flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
  - entry width constant ENTRY_W = N+ADDR_W+5.
  - occupancy type.
- Sub-module sub_wb_fifo: 2-entry storage, pointers and occupancy, with push/pop/full/empty. The top level holds flag derivation, head decode, the retire rule and the flag register.

Test Plan:
- Push diff=0x0002, bo=0, a_msb=0, b_msb=0, rd=1, flag_we=1 (5−3), rf_ready=1 -> rf_we=1, rf_waddr=1, rf_wdata=0x0002 the next cycle; flags ZNCV=0000 after retire.
- Push diff=0xFFFE, bo=1, a_msb=0, b_msb=0, rd=2, flag_we=1 (3−5) -> rf_wdata=0xFFFE; flags Z0 N1 C1 V0.
- Push diff=0x7FFF, bo=0, a_msb=1, b_msb=0, rd=3, flag_we=1 (0x8000−1) -> flags Z0 N0 C0 V1. Then diff=0x0000, bo=0, flag_we=0 -> flags unchanged at 0001 and rf_wdata=0x0000.
- rf_ready=0, three back-to-back pushes -> in_ready falls after the second accept and occupancy=2. Set rf_ready=1 -> entries retire in order and in_ready returns the cycle after the first retire.
- Push rd=0, diff=0x0000, flag_we=1, rf_ready=0 -> rf_we stays 0; entry retires in one cycle; flag_z=1.
- With occupancy=2, assert rst asynchronously mid-cycle -> occupancy=0, rf_we=0 and flags=0000 immediately. After release, in_ready=1 and no stale write appears.

Source files
------------

// File: rtl/sub_wb_pkg.sv
// Shared constants and types for the subtractor writeback stage.
// Flag bit positions, entry width and the occupancy type.
package sub_wb_pkg;

  localparam int WB_N      = 16;
  localparam int WB_ADDR_W = 3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_W = 4;

  localparam int ENTRY_W = WB_N + WB_ADDR_W + 5;

  typedef logic [1:0] occ_t;

  // Entry layout: {diff, rd, flag_we, v, c, n, z}
  function automatic int entry_width(input int n, input int aw);
    return n + aw + 5;
  endfunction

endpackage

// File: rtl/sub_writeback_stage_if.sv
// Upstream result handshake plus register-file write port.
// The stage takes the slave view, its environment the master view.
interface sub_writeback_stage_if
  import sub_wb_pkg::*;
#(
  parameter int N      = WB_N,
  parameter int ADDR_W = WB_ADDR_W
);

  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_diff;
  logic              in_bo;
  logic              in_a_msb;
  logic              in_b_msb;
  logic [ADDR_W-1:0] in_rd;
  logic              in_flag_we;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [N-1:0]      rf_wdata;
  logic              rf_ready;

  modport master (
    output in_valid, in_diff, in_bo,
    output in_a_msb, in_b_msb,
    output in_rd, in_flag_we,
    input  in_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output rf_ready
  );

  modport slave (
    input  in_valid, in_diff, in_bo,
    input  in_a_msb, in_b_msb,
    input  in_rd, in_flag_we,
    output in_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  rf_ready
  );

endinterface

// File: rtl/sub_wb_fifo.sv
// Two-entry result buffer with 1-bit wrapping pointers.
// Push is ignored when full, pop is ignored when empty.
module sub_wb_fifo
  import sub_wb_pkg::*;
#(
  parameter int W = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output occ_t         occ
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  occ_t         occ_q, occ_d;
  logic         do_push;
  logic         do_pop;

  assign full  = (occ_q == 2'd2);
  assign empty = (occ_q == 2'd0);
  assign occ   = occ_q;
  assign rdata = mem_q[rd_q];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    unique case (1'b1)
      do_push & ~do_pop: occ_d = occ_q + 2'd1;
      do_pop & ~do_push: occ_d = occ_q - 2'd1;
      default:           occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/sub_writeback_stage.sv
// Writeback stage behind the 16-bit subtractor: buffers results,
// drains them to the register file and retires Z/N/C/V flags.
module sub_writeback_stage
  import sub_wb_pkg::*;
#(
  parameter int N      = WB_N,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sub_writeback_stage_if.slave  bus,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  flag_v,
  output occ_t                  occupancy
);

  localparam int EW = entry_width(N, ADDR_W);

  if (DEPTH != 2) begin : g_depth_chk
    $error("sub_writeback_stage supports DEPTH=2 only");
  end

  logic [FLAG_W-1:0] flags_in;
  logic [EW-1:0]     entry_in;
  logic [EW-1:0]     head;
  logic              full;
  logic              empty;
  logic              push;
  logic              retire;

  logic [FLAG_W-1:0] head_flags;
  logic              head_fwe;
  logic [ADDR_W-1:0] head_rd;
  logic [N-1:0]      head_diff;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [N-1:0]      wdata_q, wdata_d;

  always_comb begin
    flags_in         = '0;
    flags_in[FLAG_Z] = (bus.in_diff == '0);
    flags_in[FLAG_N] = bus.in_diff[N-1];
    flags_in[FLAG_C] = bus.in_bo;
    flags_in[FLAG_V] = (bus.in_a_msb ^ bus.in_b_msb)
                     & (bus.in_a_msb ^ bus.in_diff[N-1]);
  end

  assign entry_in = {bus.in_diff, bus.in_rd,
                     bus.in_flag_we, flags_in};

  assign head_flags = head[FLAG_W-1:0];
  assign head_fwe   = head[FLAG_W];
  assign head_rd    = head[ADDR_W+FLAG_W:FLAG_W+1];
  assign head_diff  = head[EW-1:ADDR_W+FLAG_W+1];

  // rst gates ready so nothing is taken while reset is held
  assign bus.in_ready = ~rst & ~full;
  assign push         = bus.in_valid & bus.in_ready;

  // r0 writes are discarded, so they retire without the RF
  assign retire = ~empty
                & ((head_rd == '0) | bus.rf_ready);

  sub_wb_fifo #(
    .W (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (retire),
    .wdata (entry_in),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .occ   (occupancy)
  );

  always_comb begin
    flags_d = flags_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (retire & head_fwe) begin
      flags_d = head_flags;
    end
    if (~empty) begin
      waddr_d = head_rd;
      wdata_d = head_diff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      flags_q <= flags_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Address/data hold the last head while the buffer is empty
  assign bus.rf_we    = ~empty & (head_rd != '0);
  assign bus.rf_waddr = empty ? waddr_q : head_rd;
  assign bus.rf_wdata = empty ? wdata_q : head_diff;

  assign flag_z = flags_q[FLAG_Z];
  assign flag_n = flags_q[FLAG_N];
  assign flag_c = flags_q[FLAG_C];
  assign flag_v = flags_q[FLAG_V];

endmodule
